// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes,
// FSM state encoding and request legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Halfwords need an even byte address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return (addr_lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // Stores only exist as B/H/W; loads additionally have BU/HU.
    function automatic logic is_illegal(input logic [2:0] funct3, input logic store);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return store;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data from a memory word,
// and merges sub-word store data into a word for read-modify-write.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then sign- or zero-extend by funct3.
    always_comb begin
        byte_sel  = word[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? word[31:16] : word[15:0];
        load_data = 32'd0;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data = word;
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase
    end

    // Overlay the store bytes onto the word read back from memory.
    always_comb begin
        merged = word;
        case (funct3)
            F3_B:    merged[{addr_lo, 3'b000} +: 8]        = wdata[7:0];
            F3_H:    merged[{addr_lo[1], 4'b0000} +: 16]   = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Single-outstanding load/store initiator for the word-addressed data memory.
// Sub-word stores are done as read-modify-write; all outputs are registered.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ADDR_DATA_M,
    output logic              Mem_WE,
    output logic [31:0]       IN_DATA_M,
    input  logic [31:0]       OUT_DATA_M
);

    lsu_state_e        state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [ADDR_W-1:0] addr_m_q, addr_m_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       in_data_q, in_data_d;

    logic [31:0]       load_data;
    logic [31:0]       merged;

    lsu_lane_align u_align (
        .word      (OUT_DATA_M),
        .addr_lo   (addr_lo_q),
        .funct3    (funct3_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    // Next-state and next-output logic of the request FSM.
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        addr_m_d    = addr_m_q;
        mem_we_d    = mem_we_q;
        in_data_d   = in_data_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    store_d     = req_store;
                    funct3_d    = req_funct3;
                    addr_lo_d   = req_addr[1:0];
                    wdata_d     = req_wdata[15:0];
                    rsp_rdata_d = 32'd0;
                    if (is_illegal(req_funct3, req_store) ||
                        is_misaligned(req_funct3, req_addr[1:0])) begin
                        // Rejected requests never touch memory.
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        addr_m_d = req_addr[ADDR_W+1:2];
                        if (req_store && (req_funct3 == F3_W)) begin
                            mem_we_d  = 1'b1;
                            in_data_d = req_wdata;
                            state_d   = WRITE;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                if (store_q) begin
                    in_data_d = merged;
                    mem_we_d  = 1'b1;
                    state_d   = WRITE;
                end else begin
                    rsp_rdata_d = load_data;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            WRITE: begin
                mem_we_d    = 1'b0;
                rsp_rdata_d = 32'd0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; async reset kills any pending write at once.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            funct3_q    <= 3'd0;
            addr_lo_q   <= 2'd0;
            wdata_q     <= 16'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            addr_m_q    <= '0;
            mem_we_q    <= 1'b0;
            in_data_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            addr_m_q    <= addr_m_d;
            mem_we_q    <= mem_we_d;
            in_data_q   <= in_data_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign ADDR_DATA_M = addr_m_q;
    assign Mem_WE      = mem_we_q;
    assign IN_DATA_M   = in_data_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: directed scenarios followed by random traffic,
// checked against a byte-array memory model kept in the bench.
module tb_data_mem_lsu;

    localparam int ADDR_W = 8;

    logic              CLK = 1'b0;
    logic              RST_n = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_store = 1'b0;
    logic [2:0]        req_funct3 = 3'd0;
    logic [ADDR_W+1:0] req_addr = '0;
    logic [31:0]       req_wdata = 32'd0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] ADDR_DATA_M;
    logic              Mem_WE;
    logic [31:0]       IN_DATA_M;
    logic [31:0]       OUT_DATA_M;

    int checks = 0;
    int failures = 0;

    // Environment memory driven by the DUT
    logic [31:0] mem [0:255] = '{default: 32'd0};
    int          we_count = 0;
    logic [7:0]  last_we_addr = '0;
    logic [31:0] last_we_data = '0;

    // Reference byte-addressed memory, little-endian
    logic [7:0]  ref_b [0:1023] = '{default: 8'd0};

    always #5 CLK = ~CLK;

    assign OUT_DATA_M = mem[ADDR_DATA_M];

    always @(posedge CLK) begin
        if (Mem_WE) begin
            mem[ADDR_DATA_M] <= IN_DATA_M;
            we_count         <= we_count + 1;
            last_we_addr     <= ADDR_DATA_M;
            last_we_data     <= IN_DATA_M;
        end
    end

    data_mem_lsu #(.ADDR_W(ADDR_W)) dut (
        .CLK         (CLK),
        .RST_n       (RST_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_store   (req_store),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .ADDR_DATA_M (ADDR_DATA_M),
        .Mem_WE      (Mem_WE),
        .IN_DATA_M   (IN_DATA_M),
        .OUT_DATA_M  (OUT_DATA_M)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int widx);
        return {ref_b[4*widx+3], ref_b[4*widx+2], ref_b[4*widx+1], ref_b[4*widx]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
        chk({tag, "_addr"},      32'(ADDR_DATA_M), 32'd0);
        chk({tag, "_we"},        32'(Mem_WE), 32'd0);
        chk({tag, "_in_data"},   IN_DATA_M, 32'd0);
    endtask

    // One full transaction with 'hold' cycles of response backpressure.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [9:0] a,
                           input logic [31:0] wd, input int hold, output logic [31:0] got);
        int          size;
        logic        legal;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_we;
        int          we_before;
        int          lat;
        int          waitc;
        int          widx;

        size    = 1 << f3[1:0];
        legal   = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        exp_err = !legal || ((int'(a) % size) != 0);
        exp_rdata = 32'd0;
        if (!exp_err && !st) begin
            for (int k = 0; k < size; k++) exp_rdata |= 32'(ref_b[int'(a) + k]) << (8 * k);
            if (!f3[2] && size == 1) exp_rdata = {{24{exp_rdata[7]}}, exp_rdata[7:0]};
            if (!f3[2] && size == 2) exp_rdata = {{16{exp_rdata[15]}}, exp_rdata[15:0]};
        end
        exp_lat = exp_err ? 1 : ((st && size < 4) ? 3 : 2);
        exp_we  = (!exp_err && st) ? 1 : 0;
        widx    = int'(a) / 4;

        @(negedge CLK);
        waitc = 0;
        while (!req_ready && waitc < 10) begin
            @(negedge CLK);
            waitc++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        we_before  = we_count;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge CLK);
        #1;
        req_valid  = 1'b0;
        req_wdata  = $urandom;

        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!rsp_valid && lat < 10);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        got = rsp_rdata;

        for (int i = 0; i < hold; i++) begin
            req_valid  = 1'b1;
            req_store  = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = 10'($urandom);
            @(negedge CLK);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_rdata", rsp_rdata, exp_rdata);
            chk("hold_err", 32'(rsp_err), 32'(exp_err));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1;
        rsp_ready = 1'b0;
        @(negedge CLK);
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
        chk("post_rsp_err", 32'(rsp_err), 32'd0);

        if (exp_we == 1) begin
            for (int k = 0; k < size; k++) ref_b[int'(a) + k] = wd[8*k +: 8];
            chk("we_addr", 32'(last_we_addr), 32'(widx));
            chk("we_data", last_we_data, ref_word(widx));
        end
        chk("we_pulses", 32'(we_count - we_before), 32'(exp_we));
        chk("mem_word", mem[widx], ref_word(widx));

        $display("txn st=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 st, f3, a, wd, got, exp_err, lat);
    endtask

    initial begin
        logic [31:0] got;
        int          we_before;
        logic [9:0]  ra;

        // Reset
        #3 RST_n = 1'b0;
        #1 check_reset_outputs("reset");
        @(negedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;

        // SW then LW
        run_txn(1'b1, 3'b010, 10'h004, 32'hDEADBEEF, 0, got);
        chk("sw_we_data", last_we_data, 32'hDEADBEEF);
        run_txn(1'b0, 3'b010, 10'h004, 32'h0, 0, got);
        chk("lw_deadbeef", got, 32'hDEADBEEF);

        // SB read-modify-write
        run_txn(1'b1, 3'b010, 10'h004, 32'h11223344, 0, got);
        run_txn(1'b1, 3'b000, 10'h006, 32'h000000AA, 0, got);
        chk("sb_merge", last_we_data, 32'h11AA3344);
        run_txn(1'b0, 3'b010, 10'h004, 32'h0, 0, got);
        chk("lw_after_sb", got, 32'h11AA3344);

        // Sign and zero extension
        run_txn(1'b1, 3'b010, 10'h000, 32'h8000F080, 0, got);
        run_txn(1'b0, 3'b000, 10'h000, 32'h0, 0, got);
        chk("lb", got, 32'hFFFFFF80);
        run_txn(1'b0, 3'b100, 10'h000, 32'h0, 0, got);
        chk("lbu", got, 32'h00000080);
        run_txn(1'b0, 3'b001, 10'h002, 32'h0, 0, got);
        chk("lh", got, 32'hFFFF8000);
        run_txn(1'b0, 3'b101, 10'h002, 32'h0, 0, got);
        chk("lhu", got, 32'h00008000);

        // Errors
        run_txn(1'b0, 3'b010, 10'h002, 32'h0, 0, got);
        run_txn(1'b1, 3'b001, 10'h001, 32'h12345678, 0, got);
        run_txn(1'b1, 3'b100, 10'h000, 32'h12345678, 0, got);
        chk("mem0_after_err", mem[0], 32'h8000F080);

        // Backpressure
        run_txn(1'b0, 3'b010, 10'h004, 32'h0, 5, got);

        // Reset during the READ cycle of an SB
        @(negedge CLK);
        we_before  = we_count;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 10'h005;
        req_wdata  = 32'h00000055;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        #1 RST_n = 1'b0;
        #1 check_reset_outputs("abort");
        @(negedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;
        chk("abort_we", 32'(we_count - we_before), 32'd0);
        chk("abort_mem", mem[1], 32'h11AA3344);

        // Top word
        run_txn(1'b1, 3'b010, 10'h3FC, 32'hCAFEF00D, 0, got);
        chk("top_addr", 32'(last_we_addr), 32'h000000FF);
        run_txn(1'b0, 3'b010, 10'h3FC, 32'h0, 0, got);
        chk("top_lw", got, 32'hCAFEF00D);

        // Random traffic over a small set of words
        for (int n = 0; n < 150; n++) begin
            ra = {($urandom_range(0, 8) == 8) ? 8'hFF : 8'($urandom_range(0, 7)), 2'($urandom)};
            run_txn(1'($urandom), 3'($urandom), ra, $urandom, $urandom_range(0, 2), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
Load/store initiator that drives the DATA_memory port (ADDR_DATA_M, Mem_WE, IN_DATA_M, OUT_DATA_M) on behalf of the core pipeline. It accepts one byte-addressed RV32 load or store at a time over a valid/ready handshake. It converts each request into word-addressed memory cycles, using read-modify-write for SB/SH. It returns sign- or zero-extended load data, or an error, over a valid/ready response channel.

Parameters:
ADDR_W, 8, word-address width of DATA_memory; the byte address is ADDR_W+2 bits.

Ports:
CLK  in  1  clock; all state updates on rising edge
RST_n  in  1  asynchronous, active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_store  in  1  1=store, 0=load
req_funct3  in  3  RV32 funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  ADDR_W+2  byte address
req_wdata  in  32  store data (low bits used for B/H)
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  misaligned access or illegal funct3
ADDR_DATA_M  out  ADDR_W  word address to memory
Mem_WE  out  1  memory write enable; memory commits on the CLK edge while it is high
IN_DATA_M  out  32  write data to memory
OUT_DATA_M  in  32  combinational read data from memory

Behaviour:
- Reset (async, RST_n=0): state IDLE. req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, ADDR_DATA_M=0, Mem_WE=0, IN_DATA_M=0. Mem_WE drops immediately on reset assertion.
- All outputs are registered. One request is outstanding at most, with no pipelining.
- State IDLE (req_ready=1). On accept, latch the request and check it:
  - Error if funct3 is illegal: 011, 110 or 111, or any funct3 >010 on a store.
  - Error if misaligned: H/HU/SH with addr[0]!=0, or W/SW with addr[1:0]!=0.
  - On error, go to RESP with rsp_err=1. No memory cycle is issued.
  - Otherwise set ADDR_DATA_M=addr[ADDR_W+1:2].
  - SW: set Mem_WE=1 and IN_DATA_M=wdata, go to WRITE.
  - All loads and SB/SH: Mem_WE=0, go to READ.
- State READ (one cycle): sample OUT_DATA_M.
  - Load: select lane by addr[1:0] (byte) or addr[1] (half). Sign-extend for B/H, zero-extend for BU/HU/W. Write the result to rsp_rdata and go to RESP.
  - SB/SH: merge wdata[7:0] or wdata[15:0] into the read word at the selected lane. Set IN_DATA_M=merged and Mem_WE=1, go to WRITE.
- State WRITE (one cycle): memory commits at the end-of-cycle edge. Then set Mem_WE=0, rsp_rdata=0, and go to RESP.
- State RESP: rsp_valid=1. Hold rsp_rdata and rsp_err stable until rsp_ready. On handshake, clear rsp_valid and rsp_err and return to IDLE. req_ready stays 0 until IDLE.
- Mem_WE is high for exactly one cycle per store and never on loads or errors. ADDR_DATA_M holds its value through READ and WRITE.
- Latency from the accept edge to rsp_valid:
  - error: 1 cycle
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
- If rsp_ready is already high when rsp_valid rises, the response is consumed in that cycle. The next request can be accepted one cycle later, in IDLE.
- Reset asserted during READ aborts with memory unchanged. Reset asserted during WRITE before the edge aborts the write.
- Address wrap: the top word (ADDR_DATA_M = 2^ADDR_W-1) is legal and never wraps.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state encoding IDLE/READ/WRITE/RESP
  - a misalign-check function
- One combinational sub-module, lsu_lane_align, performs load extract/extend and store merge (inputs: word, addr[1:0], funct3, wdata).
- The FSM and registers stay in data_mem_lsu.

Test Plan:
1. SW addr 0x004, wdata 0xDEADBEEF → one Mem_WE pulse with ADDR_DATA_M=0x01 and IN_DATA_M=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_err=0. Then LW 0x004 → rsp_rdata=0xDEADBEEF.
2. Word 0x01 = 0x11223344, then SB addr 0x006 wdata 0x000000AA → READ then WRITE with IN_DATA_M=0x11AA3344; rsp_valid at cycle 3. LW 0x004 → 0x11AA3344.
3. Word 0x00 = 0x8000F080: LB 0x000 → 0xFFFFFF80; LBU 0x000 → 0x00000080; LH 0x002 → 0xFFFF8000; LHU 0x002 → 0x00008000.
4. LW 0x002, SH 0x001, and store funct3=100 → rsp_err=1 and rsp_rdata=0 after 1 cycle; Mem_WE never asserted; memory contents unchanged.
5. Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid → rsp_rdata/rsp_err stable, req_ready=0, new req_valid ignored. Then rsp_ready=1 → back in IDLE next cycle.
6. SB in progress, RST_n pulled low during READ → Mem_WE=0 and all outputs at reset values immediately; target word unchanged. SW to the top word 0x3FC (ADDR_DATA_M=0xFF) then completes normally.
